// File: rtl/dot3_stream_accum_if.sv
// Stream bundle for dot3_stream_accum.
// Sequencer side (master) drives one element pair per valid cycle;
// the accumulator side (slave) returns dot-product pulses and the
// partial-group error flag.
//   in_valid    : pair on in_a/in_b is sampled at this edge
//   in_first    : pair is element 0 of a new group (qualified by in_valid)
//   in_a, in_b  : signed fixed-point operands
//   out_valid   : one-cycle pulse, out_data/out_sat valid
//   out_data    : saturated dot product
//   out_sat     : result was clamped (only with out_valid)
//   err_partial : one-cycle pulse, a partial group was discarded
interface dot3_stream_accum_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_first;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic             err_partial;

    modport master (
        output in_valid, in_first, in_a, in_b,
        input  out_valid, out_data, out_sat, err_partial
    );

    modport slave (
        input  in_valid, in_first, in_a, in_b,
        output out_valid, out_data, out_sat, err_partial
    );
endinterface

// File: rtl/dot3_stream_accum.sv
// Serialized 3-element dot-product accumulator.
// Each valid pair (a_i, b_i) is multiplied, scaled back to QFRAC by an
// arithmetic right shift (floor), and summed in groups of three. One
// saturated result is emitted per completed group. Fully pipelined, one
// pair per cycle, no stalls.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dot3_stream_accum_if slave modport (input pairs, result pulses)
module dot3_stream_accum #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    dot3_stream_accum_if.slave   bus
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int SHR_W  = 2 * WIDTH - FRAC;
    // Two guard bits cover the sum of three scaled products.
    localparam int ACC_W  = SHR_W + 2;

    // Scale a full-precision product back to QFRAC, rounding toward -inf.
    function automatic logic signed [SHR_W-1:0] scale_prod(input logic signed [PROD_W-1:0] p);
        return SHR_W'(p >>> FRAC);
    endfunction

    // Clamp the accumulator to WIDTH signed; returns {clamped, value}.
    function automatic logic [WIDTH:0] sat_clip(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
        min_v = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
        if (v > max_v)
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        else if (v < min_v)
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, v[WIDTH-1:0]};
    endfunction

    // Control state
    logic [1:0]              idx_q, idx_d;
    logic                    vld_p0_q, vld_p0_d;
    logic                    vld_p1_q, vld_p1_d;
    logic                    vld_p2_q, vld_p2_d;
    logic                    err_partial_q, err_partial_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_sat_q, out_sat_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic signed [ACC_W-1:0] acc_p2_q, acc_p2_d;

    // Datapath state (meaningful only when the matching valid bit is set)
    logic signed [WIDTH-1:0]  a_p0_q, a_p0_d;
    logic signed [WIDTH-1:0]  b_p0_q, b_p0_d;
    logic [1:0]               tag_p0_q, tag_p0_d;
    logic signed [PROD_W-1:0] prod_p1_q, prod_p1_d;
    logic [1:0]               tag_p1_q, tag_p1_d;
    logic [1:0]               tag_p2_q, tag_p2_d;

    logic [1:0]               tag_in;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [SHR_W-1:0]  scaled;
    logic signed [ACC_W-1:0]  scaled_ext;
    logic [WIDTH:0]           clip;

    always_comb begin
        // ---- stage p0: tag and register the incoming pair ----
        tag_in        = bus.in_first ? 2'd0 : idx_q;
        idx_d         = idx_q;
        err_partial_d = 1'b0;
        if (bus.in_valid) begin
            idx_d         = (tag_in == 2'd2) ? 2'd0 : tag_in + 2'd1;
            // A forced restart while mid-group abandons the earlier pairs;
            // they never reach tag 2, so no result is produced for them.
            err_partial_d = bus.in_first && (idx_q != 2'd0);
        end
        vld_p0_d = bus.in_valid;
        a_p0_d   = bus.in_a;
        b_p0_d   = bus.in_b;
        tag_p0_d = tag_in;

        // ---- stage p1: full-precision product ----
        a_ext     = a_p0_q;
        b_ext     = b_p0_q;
        prod_p1_d = a_ext * b_ext;
        vld_p1_d  = vld_p0_q;
        tag_p1_d  = tag_p0_q;

        // ---- stage p2: scale and accumulate ----
        scaled     = scale_prod(prod_p1_q);
        scaled_ext = {{2{scaled[SHR_W-1]}}, scaled};
        acc_p2_d   = acc_p2_q;
        if (vld_p1_q)
            acc_p2_d = (tag_p1_q == 2'd0) ? scaled_ext : acc_p2_q + scaled_ext;
        vld_p2_d = vld_p1_q;
        tag_p2_d = tag_p1_q;

        // ---- stage p3: saturate and emit on the last element ----
        // acc_p2_q is read here in the same cycle a new group may load it,
        // so the result is captured before being overwritten.
        clip        = sat_clip(acc_p2_q);
        out_valid_d = vld_p2_q && (tag_p2_q == 2'd2);
        out_data_d  = out_valid_d ? clip[WIDTH-1:0] : out_data_q;
        out_sat_d   = out_valid_d && clip[WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q         <= '0;
            vld_p0_q      <= 1'b0;
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            err_partial_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sat_q     <= 1'b0;
            out_data_q    <= '0;
            acc_p2_q      <= '0;
        end else begin
            idx_q         <= idx_d;
            vld_p0_q      <= vld_p0_d;
            vld_p1_q      <= vld_p1_d;
            vld_p2_q      <= vld_p2_d;
            err_partial_q <= err_partial_d;
            out_valid_q   <= out_valid_d;
            out_sat_q     <= out_sat_d;
            out_data_q    <= out_data_d;
            acc_p2_q      <= acc_p2_d;
        end
    end

    always_ff @(posedge clock) begin
        a_p0_q    <= a_p0_d;
        b_p0_q    <= b_p0_d;
        tag_p0_q  <= tag_p0_d;
        prod_p1_q <= prod_p1_d;
        tag_p1_q  <= tag_p1_d;
        tag_p2_q  <= tag_p2_d;
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_sat     = out_sat_q;
    assign bus.err_partial = err_partial_q;

endmodule

// File: tb/tb_dot3_stream_accum.sv
// Testbench for dot3_stream_accum: directed pairs with hand-computed
// results queued as expectations; a negedge monitor pops and compares
// each output pulse (value, saturation flag, arrival cycle) and checks
// reset, hold and error-pulse behaviour.
module tb_dot3_stream_accum;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   last_cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic rst_edge = 1'b1;
    logic [WIDTH-1:0] hold_val = '0;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             s;
        int               c;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];

    dot3_stream_accum_if #(.WIDTH(WIDTH)) bus ();

    dot3_stream_accum #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (rst_edge) begin
            check("reset_out_valid", 64'(bus.out_valid), 64'd0);
            check("reset_out_data", 64'(bus.out_data), 64'd0);
            check("reset_out_sat", 64'(bus.out_sat), 64'd0);
            check("reset_err_partial", 64'(bus.err_partial), 64'd0);
            hold_val = '0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e.d));
                    check("out_sat", 64'(bus.out_sat), 64'(e.s));
                    check("out_cycle", 64'(cyc), 64'(e.c));
                    hold_val = e.d;
                end
            end else begin
                check("idle_out_sat", 64'(bus.out_sat), 64'd0);
                check("hold_out_data", 64'(bus.out_data), 64'(hold_val));
            end
            if (bus.err_partial) begin
                if (err_q.size() == 0)
                    check("unexpected_err_partial", 64'd1, 64'd0);
                else
                    check("err_cycle", 64'(cyc), 64'(err_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic f);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_a     = a;
        bus.in_b     = b;
        last_cyc     = cyc;
    endtask

    // Idle cycles; in_first is toggled to confirm it is ignored without in_valid.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            bus.in_first = 1'($urandom_range(0, 1));
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
        end
    endtask

    // Result appears four sampled edges after the third pair was driven.
    task automatic expect_out(input logic [WIDTH-1:0] d, input logic s);
        exp_t e;
        e.d = d;
        e.s = s;
        e.c = last_cyc + 4;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [WIDTH-1:0] rows [9];
        rows = '{32'h00010000, 32'h0, 32'h0,
                 32'h0, 32'h00020000, 32'h0,
                 32'h0, 32'h0, 32'h00030000};

        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(2);

        // Basic (1,2,3).(4,5,6) = 32.0
        send(32'h00010000, 32'h00040000, 1'b1);
        send(32'h00020000, 32'h00050000, 1'b0);
        send(32'h00030000, 32'h00060000, 1'b0);
        expect_out(32'h00200000, 1'b0);
        idle(6);

        // Floor rounding: each -1 LSB * 0.5 floors to -1 LSB
        send(32'hFFFFFFFF, 32'h00008000, 1'b1);
        send(32'hFFFFFFFF, 32'h00008000, 1'b0);
        send(32'hFFFFFFFF, 32'h00008000, 1'b0);
        expect_out(32'hFFFFFFFD, 1'b0);
        idle(5);

        // Positive and negative saturation, back to back
        for (int i = 0; i < 3; i++) send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'(i == 0));
        expect_out(32'h7FFFFFFF, 1'b1);
        for (int i = 0; i < 3; i++) send(32'h80000000, 32'h7FFFFFFF, 1'(i == 0));
        expect_out(32'h80000000, 1'b1);
        idle(6);

        // 3x3 matrix times (1,1,1), back to back
        for (int i = 0; i < 9; i++) begin
            send(rows[i], 32'h00010000, 1'(i == 0));
            if (i % 3 == 2) expect_out(32'(i / 3 + 1) << 16, 1'b0);
        end
        idle(6);

        // Same with random gaps
        for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            send(rows[i], 32'h00010000, 1'(i == 0));
            if (i % 3 == 2) expect_out(32'(i / 3 + 1) << 16, 1'b0);
        end
        idle(6);

        // Resync: partial group abandoned by a new in_first
        send(32'h00050000, 32'h00050000, 1'b1);
        send(32'h00050000, 32'h00050000, 1'b0);
        send(32'h00010000, 32'h00010000, 1'b1);
        err_q.push_back(last_cyc + 1);
        send(32'h00010000, 32'h00010000, 1'b0);
        send(32'h00010000, 32'h00010000, 1'b0);
        expect_out(32'h00030000, 1'b0);
        idle(6);

        // Reset after two pairs; new group without in_first relies on index reset
        send(32'h00070000, 32'h00010000, 1'b1);
        send(32'h00070000, 32'h00010000, 1'b0);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle(2);
        send(32'h00020000, 32'h00010000, 1'b0);
        send(32'h00030000, 32'h00010000, 1'b0);
        send(32'h00000000, 32'h00010000, 1'b0);
        expect_out(32'h00050000, 1'b0);
        idle(8);

        @(posedge clock);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        check("pending_errors", 64'(err_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dot3_stream_accum.md
Name: dot3_stream_accum

Overview:
- Receiving end of a serialized 3D dot-product stream. A sequencer presents one element pair (a_i, b_i) per cycle. This block multiplies each pair, accumulates the products in groups of three, and emits one dot-product result per group.
- Used as the fixed-point counterpart of the matrix/vector pipelines in the transform path. One instance serves a full 3x3 matrix-vector product when fed 9 pairs.
- Fully pipelined: accepts a new pair every cycle with no stalls.

Parameters:
- WIDTH, 32, data width of operands and result; signed two's complement
- FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC); default is Q16.16

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  pair on in_a/in_b is sampled at this edge
- in_first  in  1  qualifies in_valid; forces this pair to be element 0 of a new group
- in_a  in  WIDTH  operand a, signed QFRAC
- in_b  in  WIDTH  operand b, signed QFRAC
- out_valid  out  1  one-cycle pulse; out_data/out_sat valid
- out_data  out  WIDTH  dot product, signed QFRAC, saturated
- out_sat  out  1  with out_valid: result was clamped
- err_partial  out  1  one-cycle pulse: a partial group was discarded

Behaviour:
- Reset is synchronous, active-high; clock is clock.
- Reset values: out_valid=0, out_data=0, out_sat=0, err_partial=0, element index=0. All pipeline valid bits and the accumulator are 0.
- Reset mid-group discards all in-flight pairs and partial sums; no out_valid follows.
- Element index is a 2-bit counter cycling 0,1,2,0. It advances only on edges with in_valid=1.
- in_valid=0 cycles (gaps) are allowed anywhere; the group continues when valid returns.
- in_first=1 with in_valid=1 assigns index 0 to that pair; the counter then continues from 1.
- If in_first arrives while index≠0, the earlier partial group is dropped. err_partial pulses for one cycle following that edge, and no out_valid is produced for the dropped group.
- in_first at index 0 is legal and produces no error. in_first with in_valid=0 is ignored.
- Pipeline; the index tag and valid bit travel with the data:
  - Edge n: pair registered.
  - Edge n+1: full product a*b registered, 2*WIDTH signed.
  - Edge n+2: product arithmetically shifted right by FRAC (truncation toward -inf), then accumulated. Element 0 loads the accumulator, elements 1 and 2 add to it. Accumulator is WIDTH*2-FRAC+2 bits; no internal overflow is possible.
  - Edge n+3, when the tag is element 2: the accumulator is saturated to WIDTH signed and registered to out_data.
- Latency: third pair sampled on edge n, so out_valid is high for exactly the cycle after edge n+3.
- Saturation clamps to max 2^(WIDTH-1)-1 and min -2^(WIDTH-1). out_sat=1 exactly when a clamp occurs.
- out_data holds its value between pulses. out_sat is meaningful only with out_valid and is otherwise 0.
- Throughput: back-to-back groups (6 consecutive valid pairs) give two out_valid pulses exactly 3 cycles apart. An accumulator load for the next group never corrupts the result being output.
- There is no output backpressure; the consumer must accept every pulse.

Test Plan:
- Basic: in_first with a=(1.0,2.0,3.0)=0x00010000,0x00020000,0x00030000 and b=(4.0,5.0,6.0) on 3 consecutive edges -> single out_valid 3 cycles after the third pair, out_data=0x00200000 (32.0), out_sat=0.
- Rounding: three pairs of a=0xFFFFFFFF, b=0x00008000 -> out_data=0xFFFFFFFD (each product floors to -1 LSB), out_sat=0.
- Saturation: three pairs of 0x7FFFFFFF * 0x7FFFFFFF -> out_data=0x7FFFFFFF, out_sat=1. Three pairs of 0x80000000 * 0x7FFFFFFF -> out_data=0x80000000, out_sat=1.
- Streaming with gaps: 9 pairs (3x3 matrix rows times v=(1,1,1)), rows (1,0,0),(0,2,0),(0,0,3). First pass back-to-back, second pass with random in_valid gaps -> three pulses each pass, values 0x00010000, 0x00020000, 0x00030000. Back-to-back pulses are spaced 3 cycles apart.
- Resync: two pairs, then in_first with a new group of (1,1,1)·(1,1,1) -> err_partial pulse one cycle after the in_first edge, only one out_valid, out_data=0x00030000.
- Reset mid-operation: assert reset one cycle after the second pair of a group, then send a full new group -> outputs zero during reset, no stray out_valid, new group result correct.
